counter_10: RTL and testbench

//  Synchronous decade (mod-10) up-counter for the digital clock datapath.

---
 rtl/counter_pkg.sv | 25 ++
 rtl/counter_10_mod_incr.sv | 27 ++
 rtl/counter_10.sv | 59 +++++
 tb/tb_counter_10.sv | 118 +++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants, types and helpers for the decade counter datapath.
//   DEC_MODULUS / DEC_WIDTH : default decade modulus and digit width
//   bcd_digit_t             : one BCD digit
//   next_mod()              : wrap-increment that also clears out-of-range values
package counter_pkg;

  localparam int DEC_MODULUS = 10;
  localparam int DEC_WIDTH   = 4;

  typedef logic [3:0] bcd_digit_t;

  // Any value at or above modulus-1 goes to 0, so a terminal count wraps
  // and an illegal value (e.g. 10..15 for a decade) recovers in one step.
  function automatic bcd_digit_t next_mod(input bcd_digit_t val,
                                          input bcd_digit_t modulus);
    bcd_digit_t last;
    last = modulus - 4'd1;
    if (val >= last) begin
      next_mod = '0;
    end else begin
      next_mod = val + 4'd1;
    end
  endfunction

endpackage

// File: rtl/counter_10_mod_incr.sv
// mod_incr: combinational next-state for a mod-MODULUS up-counter.
// Ports:
//   i_val  [WIDTH-1:0]  current count
//   o_next [WIDTH-1:0]  next count: i_val+1, wrapping to 0 at MODULUS-1;
//                       any value >= MODULUS also maps to 0
module mod_incr
  import counter_pkg::*;
#(
  parameter int MODULUS = DEC_MODULUS,
  parameter int WIDTH   = DEC_WIDTH
) (
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_next
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  generate
    if (WIDTH == DEC_WIDTH) begin : g_digit
      localparam bcd_digit_t MOD_DIGIT = bcd_digit_t'(MODULUS);
      assign o_next = next_mod(i_val, MOD_DIGIT);
    end else begin : g_generic
      assign o_next = (i_val >= LAST) ? '0 : (i_val + 1'b1);
    end
  endgenerate

endmodule

// File: rtl/counter_10.sv
// counter_10: free-running synchronous decade up-counter (units digit stage).
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   rst    in   synchronous active-high reset, priority over counting
//   CNT10  out  [WIDTH-1:0] registered count 0..MODULUS-1
//   CARRY  out  terminal-count flag (only when COUNTER10_CARRY_EN is defined):
//               high while CNT10==MODULUS-1 and rst is low; drives the
//               count enable of the next (tens) stage
// Build option: COUNTER10_CARRY_EN adds the CARRY port.
module counter_10
  import counter_pkg::*;
#(
  parameter int MODULUS = DEC_MODULUS,
  parameter int WIDTH   = DEC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
`ifdef COUNTER10_CARRY_EN
  output logic [WIDTH-1:0] CNT10,
  output logic             CARRY
`else
  output logic [WIDTH-1:0] CNT10
`endif
);

  generate
    if ((MODULUS < 2) || ((2 ** WIDTH) < MODULUS)) begin : g_bad_cfg
      $error("counter_10: need MODULUS >= 2 and 2**WIDTH >= MODULUS");
    end
  endgenerate

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_next;

  mod_incr #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) u_incr (
    .i_val  (r_cnt),
    .o_next (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

  // Output comes straight from the state register, so it is glitch-free.
  assign CNT10 = r_cnt;

`ifdef COUNTER10_CARRY_EN
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  assign CARRY = (r_cnt == LAST) && !rst;
`endif

endmodule

// File: tb/tb_counter_10.sv
module tb_counter_10;

  logic       clk;
  logic       rst;
  logic [3:0] CNT10;
`ifdef COUNTER10_CARRY_EN
  logic       CARRY;
`endif

  counter_10 dut (
    .clk   (clk),
    .rst   (rst),
`ifdef COUNTER10_CARRY_EN
    .CNT10 (CNT10),
    .CARRY (CARRY)
`else
    .CNT10 (CNT10)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int model    = -1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: decade counting by the plain arithmetic rules.
  function automatic int model_next(input int cur, input bit r);
    if (r) return 0;
    if (cur < 0 || cur >= 10) return 0;
    return (cur + 1) % 10;
  endfunction

  // One clock edge of stimulus: drive rst at the falling edge, push the
  // expected value for the following rising edge.
  task automatic step(input bit r);
    @(negedge clk);
    rst   = r;
    model = model_next(model, r);
    exp_q.push_back(model);
    @(posedge clk);
  endtask

  // Monitor: every rising edge that has an expectation queued is checked.
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cnt", int'(CNT10), e);
        check("cnt_in_range", int'(CNT10 < 4'd10), 1);
`ifdef COUNTER10_CARRY_EN
        check("carry", int'(CARRY), int'(e == 9 && rst == 1'b0));
`endif
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1;

    // Reset held over two edges
    step(1'b1);
    step(1'b1);

    // Release: 1..9, then wrap and keep running with period 10
    for (int i = 0; i < 9; i++) step(1'b0);
    for (int i = 0; i < 50; i++) step(1'b0);

    // Mid-count reset at 5
    guard = 0;
    while (model != 5 && guard < 20) begin
      step(1'b0);
      guard++;
    end
    check("reach_five", model, 5);
    step(1'b1);
    step(1'b0);
    step(1'b0);

    // Illegal state injection
    #2;
    force dut.r_cnt = 4'd12;
    #1;
    release dut.r_cnt;
    model = 12;
    #1;
    check("forced_value", int'(CNT10), 12);
    step(1'b0);
    step(1'b0);
    step(1'b0);

    // Randomised reset pulses on a free-running counter
    for (int i = 0; i < 300; i++) step($urandom_range(0, 7) == 0);
    step(1'b0);

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
